// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage miniRV pipeline: load-use interlock,
// EX redirect flush, data-memory wait freeze, plus saturating stall/flush counters.
module hazard_ctrl #(
  parameter logic [2:0] RF_WSEL_LOAD = 3'b010,
  parameter int         CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic [4:0]       ex_wR,
  input  logic             ex_rf_we,
  input  logic [2:0]       ex_rf_wsel,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pipline_stop,
  output logic [3:0]       pipline_stop_info,
  output logic             hold_all,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [3:0] INFO_MEM   = 4'b0011;
  localparam logic [3:0] INFO_FLUSH = 4'b1100;
  localparam logic [3:0] INFO_LOAD  = 4'b0111;

  state_t state, state_next;

  logic load_in_ex;
  logic rs1_hit;
  logic rs2_hit;
  logic lu;
  logic mw;
  logic lu_stall;
  logic redirect_go;
  logic stall_evt;

  // Memory handshake: mem_req marks a RAM access issued by MEM this cycle and
  // mem_ready marks its completion in the same cycle; req & ~ready is a wait state.
  assign mw = mem_req & ~mem_ready;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign load_in_ex = ex_rf_we & (ex_rf_wsel == RF_WSEL_LOAD) & (ex_wR != 5'd0);
  assign rs1_hit    = id_re1 & (id_rs1 == ex_wR);
  assign rs2_hit    = id_re2 & (id_rs2 == ex_wR);
  assign lu         = load_in_ex & (rs1_hit | rs2_hit);

  // A redirect kills the ID instruction, so its load-use match is irrelevant.
  assign lu_stall    = lu & ~ex_redirect & ~mw;
  assign redirect_go = ex_redirect & ~mw;
  assign stall_evt   = mw | lu_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (mw) begin
          state_next = MEM_WAIT;
        end else if (lu & ~ex_redirect) begin
          state_next = LOAD_STALL;
        end else begin
          state_next = RUN;
        end
      end
      LOAD_STALL: begin
        state_next = mw ? MEM_WAIT : RUN;
      end
      MEM_WAIT: begin
        state_next = mw ? MEM_WAIT : RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Stop outputs are gated by rst so they drop in the same cycle reset arrives.
  always_comb begin
    pipline_stop_info = 4'b0000;
    hold_all          = 1'b0;
    if (!rst) begin
      if (mw) begin
        pipline_stop_info = INFO_MEM;
        hold_all          = 1'b1;
      end else if (redirect_go) begin
        pipline_stop_info = INFO_FLUSH;
      end else if (lu_stall) begin
        pipline_stop_info = INFO_LOAD;
      end
    end
  end

  assign pipline_stop = (|pipline_stop_info) | hold_all;
  assign fsm_state    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (redirect_go && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a rule-level model (a 32-bit and a 4-bit instance).
module tb_hazard_ctrl;

  localparam int S_RUN = 0;
  localparam int S_LS  = 1;
  localparam int S_MW  = 2;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_wR;
  logic       id_re1, id_re2, ex_rf_we, ex_redirect, mem_req, mem_ready;
  logic [2:0] ex_rf_wsel;

  logic        stop_w, hold_w;
  logic [3:0]  info_w;
  logic [31:0] stall_w, flush_w;
  logic [1:0]  state_w;

  logic        stop_n, hold_n;
  logic [3:0]  info_n;
  logic [3:0]  stall_n, flush_n;
  logic [1:0]  state_n;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl #(.RF_WSEL_LOAD(3'b010), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1),
    .id_re2(id_re2), .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_rf_wsel(ex_rf_wsel),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .pipline_stop(stop_w), .pipline_stop_info(info_w), .hold_all(hold_w),
    .stall_cnt(stall_w), .flush_cnt(flush_w), .fsm_state(state_w)
  );

  hazard_ctrl #(.RF_WSEL_LOAD(3'b010), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1),
    .id_re2(id_re2), .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_rf_wsel(ex_rf_wsel),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .pipline_stop(stop_n), .pipline_stop_info(info_n), .hold_all(hold_n),
    .stall_cnt(stall_n), .flush_cnt(flush_n), .fsm_state(state_n)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: rule-level hazard conditions, episode state, unbounded event totals
  wire m_mw = mem_req & ~mem_ready;
  wire m_lu = ex_rf_we && ex_rf_wsel == 3'b010 && ex_wR != 5'd0 &&
              ((id_re1 && id_rs1 == ex_wR) || (id_re2 && id_rs2 == ex_wR));

  int     m_state = S_RUN;
  longint m_stall = 0;
  longint m_flush = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= S_RUN;
      m_stall <= 0;
      m_flush <= 0;
    end else begin
      if (m_mw || (m_lu && !ex_redirect)) m_stall <= m_stall + 1;
      if (ex_redirect && !m_mw) m_flush <= m_flush + 1;
      if (m_mw) m_state <= S_MW;
      else if (m_state == S_RUN && m_lu && !ex_redirect) m_state <= S_LS;
      else m_state <= S_RUN;
    end
  end

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic expect_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always begin
    logic [3:0] e_info;
    logic       e_hold;
    @(negedge clk);
    #2;
    e_info = 4'b0000;
    e_hold = 1'b0;
    if (!rst) begin
      if (m_mw) begin
        e_info = 4'b0011;
        e_hold = 1'b1;
      end else if (ex_redirect) begin
        e_info = 4'b1100;
      end else if (m_lu) begin
        e_info = 4'b0111;
      end
    end
    expect_eq("cmp_info",    64'(info_w),  64'(e_info));
    expect_eq("cmp_hold",    64'(hold_w),  64'(e_hold));
    expect_eq("cmp_stop",    64'(stop_w),  64'(e_hold | (|e_info)));
    expect_eq("cmp_state",   64'(state_w), 64'(m_state));
    expect_eq("cmp_stall",   64'(stall_w), 64'(sat(m_stall, 32)));
    expect_eq("cmp_flush",   64'(flush_w), 64'(sat(m_flush, 32)));
    expect_eq("cmp_info_n",  64'(info_n),  64'(e_info));
    expect_eq("cmp_stall_n", 64'(stall_n), 64'(sat(m_stall, 4)));
    expect_eq("cmp_flush_n", 64'(flush_n), 64'(sat(m_flush, 4)));
  end

  // Driver tasks
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic re1,
                       input logic re2, input logic [4:0] wr, input logic we,
                       input logic [2:0] wsel, input logic redir, input logic req,
                       input logic rdy);
    @(negedge clk);
    id_rs1 = rs1; id_rs2 = rs2; id_re1 = re1; id_re2 = re2;
    ex_wR = wr; ex_rf_we = we; ex_rf_wsel = wsel;
    ex_redirect = redir; mem_req = req; mem_ready = rdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic memwait(input logic redir);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, redir, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    id_rs1 = '0; id_rs2 = '0; id_re1 = 0; id_re2 = 0; ex_wR = '0;
    ex_rf_we = 0; ex_rf_wsel = '0; ex_redirect = 0; mem_req = 0; mem_ready = 0;
    repeat (2) @(negedge clk);
    #3;
    expect_eq("rst_info",  64'(info_w),  64'd0);
    expect_eq("rst_stop",  64'(stop_w),  64'd0);
    expect_eq("rst_state", 64'(state_w), 64'(S_RUN));
    expect_eq("rst_stall", 64'(stall_w), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Load x5 in EX, ID reads x5 through rs1
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
    #3;
    expect_eq("lu_info",  64'(info_w),  64'b0111);
    expect_eq("lu_stop",  64'(stop_w),  64'd1);
    expect_eq("lu_state", 64'(state_w), 64'(S_RUN));
    idle(); #3;
    expect_eq("lu_state_ls", 64'(state_w), 64'(S_LS));
    expect_eq("lu_stall",    64'(stall_w), 64'd1);
    expect_eq("lu_info_off", 64'(info_w),  64'd0);
    idle(); #3;
    expect_eq("lu_state_back", 64'(state_w), 64'(S_RUN));

    // Load into x0 read by ID: no hazard
    drive(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
    #3;
    expect_eq("x0_info", 64'(info_w), 64'd0);
    idle(); #3;
    expect_eq("x0_stall", 64'(stall_w), 64'd1);
    expect_eq("x0_state", 64'(state_w), 64'(S_RUN));

    // Redirect together with a load-use match: flush wins
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0);
    #3;
    expect_eq("rd_info", 64'(info_w), 64'b1100);
    idle(); #3;
    expect_eq("rd_flush", 64'(flush_w), 64'd1);
    expect_eq("rd_stall", 64'(stall_w), 64'd1);
    expect_eq("rd_state", 64'(state_w), 64'(S_RUN));

    // Three-cycle memory wait
    for (int i = 0; i < 3; i++) begin
      memwait(1'b0); #3;
      expect_eq("mw_hold", 64'(hold_w), 64'd1);
      expect_eq("mw_info", 64'(info_w), 64'b0011);
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    #3;
    expect_eq("mw_done_hold",  64'(hold_w),  64'd0);
    expect_eq("mw_done_state", 64'(state_w), 64'(S_MW));
    expect_eq("mw_stall",      64'(stall_w), 64'd4);
    idle(); #3;
    expect_eq("mw_back_state", 64'(state_w), 64'(S_RUN));

    // Redirect held across a two-cycle memory wait
    for (int i = 0; i < 2; i++) begin
      memwait(1'b1); #3;
      expect_eq("mwrd_info", 64'(info_w), 64'b0011);
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
    #3;
    expect_eq("mwrd_flush_info", 64'(info_w), 64'b1100);
    idle(); #3;
    expect_eq("mwrd_flush", 64'(flush_w), 64'd2);
    expect_eq("mwrd_stall", 64'(stall_w), 64'd6);

    // Narrow instance: bring stall_cnt to all-ones minus 1, then saturate
    for (int i = 0; i < 8; i++) memwait(1'b0);
    idle(); #3;
    expect_eq("sat_pre", 64'(stall_n), 64'd14);
    for (int i = 0; i < 4; i++) memwait(1'b0);
    #3;
    expect_eq("sat_stick", 64'(stall_n), 64'd15);
    expect_eq("sat_wide",  64'(stall_w), 64'd17);
    expect_eq("sat_state", 64'(state_w), 64'(S_MW));

    // Reset mid-MEM_WAIT while mem wait inputs stay asserted
    rst = 1'b1;
    #1;
    expect_eq("rstmw_hold",    64'(hold_w),  64'd0);
    expect_eq("rstmw_info",    64'(info_w),  64'd0);
    expect_eq("rstmw_stop",    64'(stop_w),  64'd0);
    expect_eq("rstmw_stall",   64'(stall_w), 64'd0);
    expect_eq("rstmw_stall_n", 64'(stall_n), 64'd0);
    expect_eq("rstmw_state",   64'(state_w), 64'(S_RUN));
    idle();
    rst = 1'b0;

    // Random stimulus, biased toward register matches and loads
    for (int i = 0; i < 3000; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) != 0) ? 3'b010 : 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 30),
            1'($urandom_range(0, 1)));
    end
    idle();
    @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
